// File: rtl/redir_if.sv
// redir_if: PC-redirect request/response bundle between the pipeline and pc_redirect_ctrl
//   master (pipeline): drives stall, the ex/jmp/pred request pulses and their target addresses
//   slave (controller): drives pc_control/pc_address, flushes, one-hot ack, drop, busy, statistics
interface redir_if #(parameter int XLEN = 32);
  logic stall, ex_redir_req, jmp_redir_req, pred_redir_req;
  logic [XLEN-1:0] ex_redir_addr, jmp_redir_addr, pred_redir_addr;
  logic pc_control, if_id_flush, id_ex_flush, drop, busy;
  logic [XLEN-1:0] pc_address;
  logic [2:0] redir_ack;
  logic [15:0] ex_cnt, jmp_cnt, pred_cnt, drop_cnt;
  modport master(
    output stall, ex_redir_req, jmp_redir_req, pred_redir_req,
    output ex_redir_addr, jmp_redir_addr, pred_redir_addr,
    input pc_control, pc_address, if_id_flush, id_ex_flush, redir_ack, drop, busy,
    input ex_cnt, jmp_cnt, pred_cnt, drop_cnt
  );
  modport slave(
    input stall, ex_redir_req, jmp_redir_req, pred_redir_req,
    input ex_redir_addr, jmp_redir_addr, pred_redir_addr,
    output pc_control, pc_address, if_id_flush, id_ex_flush, redir_ack, drop, busy,
    output ex_cnt, jmp_cnt, pred_cnt, drop_cnt
  );
endinterface

// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl: fixed-priority PC redirect arbiter (ex > jmp > pred) with stall hold and wrong-path shadow window
//   clk, rst (async, active-high); bus: redir_if.slave carrying requests, stall and all registered outputs
//   REDIR_STATS_EN: when defined, enables saturating 16-bit issue/drop counters; otherwise they read 0
module pc_redirect_ctrl #(
  parameter int XLEN = 32,
  parameter int SHADOW_CYCLES = 2
) (
  input logic clk,
  input logic rst,
  redir_if.slave bus
);
  typedef enum logic [1:0] {IDLE, HOLD, SHADOW} state_t;
  state_t state, state_n;
  logic [1:0] pend_lvl, shad_lvl, new_lvl, cand_lvl;
  logic [XLEN-1:0] pend_addr, new_addr, cand_addr;
  logic [2:0] cnt, cnt_n, req, live;
  logic shadow, pend, new_v, take_new, cand_v, issue, drop_n;
  assign req = {bus.pred_redir_req, bus.jmp_redir_req, bus.ex_redir_req};
  assign shadow = cnt != 3'd0;
  assign pend = state == HOLD;
  assign bus.busy = state != IDLE;
  always_comb begin
    live = {req[2] & ~(shadow & (shad_lvl < 2'd2)), req[1] & ~(shadow & (shad_lvl == 2'd0)), req[0]};
    new_v = |live;
    new_lvl = live[0] ? 2'd0 : live[1] ? 2'd1 : 2'd2;
    new_addr = live[0] ? bus.ex_redir_addr : live[1] ? bus.jmp_redir_addr : bus.pred_redir_addr;
    // while stalled an equal-priority request replaces pending; on release pending wins ties
    take_new = new_v & (~pend | (bus.stall ? new_lvl <= pend_lvl : new_lvl < pend_lvl));
    cand_v = pend | new_v;
    cand_lvl = take_new ? new_lvl : pend_lvl;
    cand_addr = take_new ? new_addr : pend_addr;
    issue = cand_v & ~bus.stall;
    drop_n = |(req & ~(take_new ? 3'b001 << new_lvl : 3'b000)) | (pend & take_new);
    cnt_n = issue ? (cand_lvl == 2'd0 ? 3'(SHADOW_CYCLES) : {2'b00, cand_lvl == 2'd1})
                  : cnt - {2'b00, ~bus.stall & shadow};
    state_n = (cand_v & bus.stall) ? HOLD : cnt_n != 3'd0 ? SHADOW : IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      shad_lvl <= '0;
      pend_lvl <= '0;
      pend_addr <= '0;
      bus.pc_control <= 1'b0;
      bus.pc_address <= '0;
      bus.if_id_flush <= 1'b0;
      bus.id_ex_flush <= 1'b0;
      bus.redir_ack <= '0;
      bus.drop <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      shad_lvl <= issue ? cand_lvl : shad_lvl;
      pend_lvl <= cand_lvl;
      pend_addr <= cand_addr;
      bus.pc_control <= issue;
      bus.pc_address <= issue ? cand_addr : '0;
      bus.if_id_flush <= issue;
      bus.id_ex_flush <= issue & (cand_lvl == 2'd0);
      bus.redir_ack <= issue ? 3'b001 << cand_lvl : 3'b000;
      bus.drop <= drop_n;
    end
`ifdef REDIR_STATS_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bus.ex_cnt <= '0;
      bus.jmp_cnt <= '0;
      bus.pred_cnt <= '0;
      bus.drop_cnt <= '0;
    end else begin
      if (issue && cand_lvl == 2'd0 && bus.ex_cnt != 16'hFFFF) bus.ex_cnt <= bus.ex_cnt + 16'd1;
      if (issue && cand_lvl == 2'd1 && bus.jmp_cnt != 16'hFFFF) bus.jmp_cnt <= bus.jmp_cnt + 16'd1;
      if (issue && cand_lvl == 2'd2 && bus.pred_cnt != 16'hFFFF) bus.pred_cnt <= bus.pred_cnt + 16'd1;
      if (drop_n && bus.drop_cnt != 16'hFFFF) bus.drop_cnt <= bus.drop_cnt + 16'd1;
    end
`else
  assign bus.ex_cnt = '0;
  assign bus.jmp_cnt = '0;
  assign bus.pred_cnt = '0;
  assign bus.drop_cnt = '0;
`endif
endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// tb_pc_redirect_ctrl: directed vectors against a priority/queue model of the redirect controller plus literal expectations
module tb_pc_redirect_ctrl;
  localparam int SC = 2;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int failures = 0;
  redir_if #(.XLEN(32)) bus();
  pc_redirect_ctrl #(.XLEN(32), .SHADOW_CYCLES(SC)) dut(.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  // model: pending request (-1 none), remaining shadow window and its priority, stats counts
  int pend = -1, win = 0, wpri = 0;
  logic [31:0] paddr = 0;
  int m_cnt [4] = '{0, 0, 0, 0};
  logic e_pc = 0, e_ifid = 0, e_idex = 0, e_drop = 0, e_busy = 0;
  logic [31:0] e_addr = 0;
  logic [2:0] e_ack = 0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", n, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [2:0] r;
    logic [31:0] a [3];
    int best;
    bit d;
    r = {bus.pred_redir_req, bus.jmp_redir_req, bus.ex_redir_req};
    a[0] = bus.ex_redir_addr; a[1] = bus.jmp_redir_addr; a[2] = bus.pred_redir_addr;
    best = -1;
    d = 0;
    for (int p = 0; p < 3; p++)
      if (r[p]) begin
        if ((win > 0 && p > wpri) || best >= 0) d = 1;
        else best = p;
      end
    if (best >= 0) begin
      if (pend < 0) begin pend = best; paddr = a[best]; end
      else if (bus.stall ? best <= pend : best < pend) begin d = 1; pend = best; paddr = a[best]; end
      else d = 1;
    end
    {e_pc, e_ifid, e_idex} = 3'b000;
    e_addr = 0;
    e_ack = 0;
    if (!bus.stall && pend >= 0) begin
      e_pc = 1; e_ifid = 1; e_idex = (pend == 0); e_addr = paddr; e_ack = 3'(1 << pend);
      win = pend == 0 ? SC : pend == 1 ? 1 : 0;
      wpri = pend;
`ifdef REDIR_STATS_EN
      if (m_cnt[pend] < 65535) m_cnt[pend]++;
`endif
      pend = -1;
    end else if (!bus.stall && win > 0) win--;
`ifdef REDIR_STATS_EN
    if (d && m_cnt[3] < 65535) m_cnt[3]++;
`endif
    e_drop = d;
    e_busy = pend >= 0 || win > 0;
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      pend = -1; win = 0; wpri = 0; paddr = 0;
      m_cnt = '{0, 0, 0, 0};
      {e_pc, e_ifid, e_idex, e_drop, e_busy} = 5'b0;
      e_addr = 0; e_ack = 0;
    end else model_step();
  end

  always @(negedge clk) begin
    chk("m_pc_control", bus.pc_control, e_pc);
    chk("m_pc_address", bus.pc_address, e_addr);
    chk("m_if_id_flush", bus.if_id_flush, e_ifid);
    chk("m_id_ex_flush", bus.id_ex_flush, e_idex);
    chk("m_redir_ack", bus.redir_ack, e_ack);
    chk("m_drop", bus.drop, e_drop);
    chk("m_busy", bus.busy, e_busy);
    chk("m_ex_cnt", bus.ex_cnt, m_cnt[0]);
    chk("m_jmp_cnt", bus.jmp_cnt, m_cnt[1]);
    chk("m_pred_cnt", bus.pred_cnt, m_cnt[2]);
    chk("m_drop_cnt", bus.drop_cnt, m_cnt[3]);
  end

  // apply one cycle of inputs (r = {pred,jmp,ex}); returns just after the edge that samples them
  task automatic cyc(input logic [2:0] r, input logic [31:0] ea, input logic [31:0] ja,
                     input logic [31:0] pa, input logic s);
    {bus.pred_redir_req, bus.jmp_redir_req, bus.ex_redir_req} = r;
    bus.ex_redir_addr = ea; bus.jmp_redir_addr = ja; bus.pred_redir_addr = pa;
    bus.stall = s;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(3'b000, 0, 0, 0, 1'b0);
  endtask

  initial begin
    bus.stall = 0;
    {bus.pred_redir_req, bus.jmp_redir_req, bus.ex_redir_req} = 3'b000;
    bus.ex_redir_addr = 0; bus.jmp_redir_addr = 0; bus.pred_redir_addr = 0;
    #1 rst = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc_control", bus.pc_control, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_ack", bus.redir_ack, 0);
    @(negedge clk) rst = 0;
    @(posedge clk);
    #1;
    cyc(3'b111, 32'h100, 32'h200, 32'h300, 1'b0);
    chk("all3_addr", bus.pc_address, 32'h100);
    chk("all3_ifid", bus.if_id_flush, 1);
    chk("all3_idex", bus.id_ex_flush, 1);
    chk("all3_ack", bus.redir_ack, 3'b001);
    chk("all3_drop", bus.drop, 1);
    cyc(3'b100, 0, 0, 32'h40, 1'b0);
    chk("shadow_pc", bus.pc_control, 0);
    chk("shadow_drop", bus.drop, 1);
    idle(1);
    cyc(3'b100, 0, 0, 32'h40, 1'b0);
    chk("postwin_addr", bus.pc_address, 32'h40);
    chk("postwin_ack", bus.redir_ack, 3'b100);
    cyc(3'b100, 0, 0, 32'h24, 1'b0);
    chk("pred_pc", bus.pc_control, 1);
    chk("pred_ifid", bus.if_id_flush, 1);
    chk("pred_idex", bus.id_ex_flush, 0);
    chk("pred_ack", bus.redir_ack, 3'b100);
    idle(1);
    chk("pred_busy", bus.busy, 0);
    cyc(3'b010, 0, 32'h80, 0, 1'b1);
    chk("st1_pc", bus.pc_control, 0);
    chk("st1_drop", bus.drop, 0);
    chk("st1_busy", bus.busy, 1);
    cyc(3'b001, 32'h500, 0, 0, 1'b1);
    chk("st2_pc", bus.pc_control, 0);
    chk("st2_drop", bus.drop, 1);
    cyc(3'b000, 0, 0, 0, 1'b1);
    chk("st3_drop", bus.drop, 0);
    idle(1);
    chk("strel_addr", bus.pc_address, 32'h500);
    chk("strel_ack", bus.redir_ack, 3'b001);
    idle(3);
    cyc(3'b010, 0, 32'h600, 0, 1'b0);
    chk("jmp_ack", bus.redir_ack, 3'b010);
    chk("jmp_idex", bus.id_ex_flush, 0);
    cyc(3'b110, 0, 32'h640, 32'h700, 1'b0);
    chk("jshad_addr", bus.pc_address, 32'h640);
    chk("jshad_drop", bus.drop, 1);
    idle(2);
    cyc(3'b001, 32'h900, 0, 0, 1'b0);
    cyc(3'b001, 32'h904, 0, 0, 1'b0);
    chk("b2b_addr", bus.pc_address, 32'h904);
    idle(3);
    cyc(3'b010, 0, 32'h111, 0, 1'b1);
    cyc(3'b010, 0, 32'h222, 0, 1'b0);
    chk("tie_addr", bus.pc_address, 32'h111);
    chk("tie_drop", bus.drop, 1);
    cyc(3'b001, 32'h10, 0, 0, 1'b1);
    cyc(3'b100, 0, 0, 32'h20, 1'b1);
    chk("low_drop", bus.drop, 1);
    idle(1);
    chk("low_addr", bus.pc_address, 32'h10);
    idle(3);
    cyc(3'b010, 0, 32'h77, 0, 1'b1);
    chk("hold_busy", bus.busy, 1);
    {bus.pred_redir_req, bus.jmp_redir_req, bus.ex_redir_req} = 3'b000;
    bus.stall = 0;
    #2 rst = 1;
    #1;
    chk("arst_busy", bus.busy, 0);
    chk("arst_pc", bus.pc_control, 0);
    @(negedge clk) rst = 0;
    @(posedge clk);
    #1;
    chk("postrst_pc", bus.pc_control, 0);
    chk("postrst_ex_cnt", bus.ex_cnt, 0);
    chk("postrst_drop_cnt", bus.drop_cnt, 0);
`ifdef REDIR_STATS_EN
    cyc(3'b010, 0, 32'h4, 0, 1'b0);
    cyc(3'b110, 0, 32'h8, 32'hc, 1'b0);
    chk("stat_jmp", bus.jmp_cnt, 2);
    chk("stat_drop", bus.drop_cnt, 1);
    bus.jmp_redir_req = 0;
    bus.pred_redir_req = 0;
    bus.ex_redir_req = 1;
    bus.ex_redir_addr = 32'h1000;
    repeat (70000) @(posedge clk);
    #1;
    chk("stat_ex_sat", bus.ex_cnt, 16'hFFFF);
`else
    cyc(3'b001, 32'h4, 0, 0, 1'b0);
    chk("nostat_ex", bus.ex_cnt, 0);
`endif
    idle(2);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
